// File: rtl/g_alu32_v1.sv
// 32-bit ALU (AND/OR/XOR/NOT/ADD/LSHIFT/RSHIFT/TRUNC) with every output registered.
// Optional zero flag output ZF is built only when G_ALU32_ZERO_FLAG_EN is defined.
module g_alu32_v1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        CI,
  input  logic [2:0]  A,
  output logic [31:0] FinalOut,
  output logic        CO
`ifdef G_ALU32_ZERO_FLAG_EN
  ,
  output logic        ZF
`endif
);

  logic [4:0]  w_n;
  logic [31:0] w_sum;
  logic        w_carry;
  logic [31:0] w_lsh;
  logic [31:0] w_rsh;
  logic [31:0] w_mask;
  logic [31:0] w_next_out;
  logic        w_next_co;

  logic [31:0] r_out;
  logic        r_co;

  // Only the low five bits matter, so an amount of 32 wraps to 0.
  assign w_n = In2[4:0];

  assign {w_carry, w_sum} = {1'b0, In1} + {1'b0, In2} + {32'd0, CI};

  // Five-stage barrel shifters: stage s moves by 2**s when bit s of the amount is set.
  always_comb begin
    w_lsh = In1;
    w_rsh = In1;
    for (int s = 0; s < 5; s++) begin
      if (w_n[s]) begin
        w_lsh = w_lsh << (1 << s);
        w_rsh = w_rsh >> (1 << s);
      end
    end
  end

  // Low n bits set; n = 0 yields an empty mask so TRUNC returns zero.
  assign w_mask = ~(32'hFFFF_FFFF << w_n);

  always_comb begin
    w_next_out = 32'd0;
    w_next_co  = 1'b0;
    case (A)
      3'd0: w_next_out = In1 & In2;
      3'd1: w_next_out = In1 | In2;
      3'd2: w_next_out = In1 ^ In2;
      3'd3: w_next_out = ~In1;
      3'd4: begin
        w_next_out = w_sum;
        w_next_co  = w_carry;
      end
      3'd5: w_next_out = w_lsh;
      3'd6: w_next_out = w_rsh;
      default: w_next_out = In1 & w_mask;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= 32'd0;
      r_co  <= 1'b0;
    end else begin
      r_out <= w_next_out;
      r_co  <= w_next_co;
    end
  end

  assign FinalOut = r_out;
  assign CO       = r_co;

`ifdef G_ALU32_ZERO_FLAG_EN
  logic r_zf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b0;
    end else begin
      r_zf <= (w_next_out == 32'd0);
    end
  end

  assign ZF = r_zf;
`endif

endmodule

// File: tb/tb_g_alu32_v1.sv
// Self-checking bench for g_alu32_v1: a reference model checked every cycle,
// directed literal vectors, asynchronous reset checks and a random opcode sweep.
module tb_g_alu32_v1;

  logic        clk;
  logic        rst;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        CI;
  logic [2:0]  A;
  logic [31:0] FinalOut;
  logic        CO;
`ifdef G_ALU32_ZERO_FLAG_EN
  logic        ZF;
`endif

  int checks;
  int errors;

  logic        lit_en;
  logic [31:0] lit_out;
  logic        lit_co;
  logic        async_req;
  logic        done;

  g_alu32_v1 dut (
    .clk      (clk),
    .rst      (rst),
    .In1      (In1),
    .In2      (In2),
    .CI       (CI),
    .A        (A),
    .FinalOut (FinalOut),
    .CO       (CO)
`ifdef G_ALU32_ZERO_FLAG_EN
    ,
    .ZF       (ZF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {carry, result} straight from the operation table.
  function automatic logic [32:0] model(input logic [2:0] a, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci);
    int n;
    logic [32:0] r;
    n = int'(y[4:0]);
    r = 33'd0;
    case (a)
      3'd0: r = {1'b0, x & y};
      3'd1: r = {1'b0, x | y};
      3'd2: r = {1'b0, x ^ y};
      3'd3: r = {1'b0, ~x};
      3'd4: r = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      3'd5: r = {1'b0, x << n};
      3'd6: r = {1'b0, x >> n};
      default: begin
        for (int i = 0; i < 32; i++) begin
          if (i < n) r[i] = x[i];
        end
      end
    endcase
    return r;
  endfunction

  // Single compare process: clock edges check model and literals, async_req checks reset.
  always begin
    logic [32:0] exp;
    logic        le;
    logic [31:0] lo;
    logic        lc;
    @(posedge clk or posedge async_req);
    if (!clk) begin
      #1;
      checks++;
      if (FinalOut !== 32'd0 || CO !== 1'b0) begin
        errors++;
        $display("FAIL async_reset: FinalOut=%08h CO=%b, required 00000000 0", FinalOut, CO);
      end
`ifdef G_ALU32_ZERO_FLAG_EN
      checks++;
      if (ZF !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_zf: ZF=%b, required 0", ZF);
      end
`endif
    end else begin
      exp = rst ? 33'd0 : model(A, In1, In2, CI);
      le  = lit_en && !rst;
      lo  = lit_out;
      lc  = lit_co;
      #2;
      checks++;
      if (FinalOut !== exp[31:0] || CO !== exp[32]) begin
        errors++;
        $display("FAIL model t=%0t A=%0d: FinalOut=%08h CO=%b, required %08h %b",
                 $time, A, FinalOut, CO, exp[31:0], exp[32]);
      end
`ifdef G_ALU32_ZERO_FLAG_EN
      checks++;
      if (ZF !== (!rst && exp[31:0] == 32'd0)) begin
        errors++;
        $display("FAIL model_zf t=%0t: ZF=%b, required %b", $time, ZF, !rst && exp[31:0] == 32'd0);
      end
`endif
      if (le) begin
        checks++;
        if (FinalOut !== lo || CO !== lc) begin
          errors++;
          $display("FAIL literal t=%0t A=%0d: FinalOut=%08h CO=%b, required %08h %b",
                   $time, A, FinalOut, CO, lo, lc);
        end else begin
          $display("txn A=%0d FinalOut=%08h CO=%b ok", A, FinalOut, CO);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] a, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic le, input logic [31:0] lo, input logic lc);
    @(negedge clk);
    A       = a;
    In1     = x;
    In2     = y;
    CI      = ci;
    lit_en  = le;
    lit_out = lo;
    lit_co  = lc;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done      = 1'b0;
    lit_en    = 1'b0;
    lit_out   = 32'd0;
    lit_co    = 1'b0;
    async_req = 1'b0;
    rst       = 1'b1;
    In1       = 32'hFFFF_FFFF;
    In2       = 32'h0000_0001;
    CI        = 1'b1;
    A         = 3'd4;
    #1 async_req = 1'b1;

    // Release reset: first edge with rst=0 gives 0xFFFFFFFF + 1 + 1.
    @(negedge clk);
    async_req = 1'b0;
    rst       = 1'b0;
    lit_en    = 1'b1;
    lit_out   = 32'h0000_0001;
    lit_co    = 1'b1;

    drive(3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1, 32'h00F0_00F0, 1'b0);
    drive(3'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1, 32'hFFF0_FFF0, 1'b0);
    drive(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b1, 32'hFF00_FF00, 1'b0);
    drive(3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b1, 32'h0F0F_0F0F, 1'b0);
    drive(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    drive(3'd4, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    drive(3'd5, 32'h8000_0001, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
    drive(3'd6, 32'h8000_0001, 32'h0000_0004, 1'b0, 1'b1, 32'h0800_0000, 1'b0);
    drive(3'd5, 32'h8000_0001, 32'h0000_0020, 1'b0, 1'b1, 32'h8000_0001, 1'b0);
    drive(3'd6, 32'h8000_0001, 32'hFFFF_FFE0, 1'b1, 1'b1, 32'h8000_0001, 1'b0);
    drive(3'd7, 32'hDEAD_BEEF, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_00EF, 1'b0);
    drive(3'd7, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    drive(3'd7, 32'hDEAD_BEEF, 32'h0000_001F, 1'b0, 1'b1, 32'h5EAD_BEEF, 1'b0);
    drive(3'd4, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 32'h2345_678A, 1'b0);

    // Mid-operation reset: the pending sum must be discarded without a clock edge.
    @(negedge clk);
    lit_en    = 1'b0;
    A         = 3'd1;
    In1       = 32'hA5A5_A5A5;
    rst       = 1'b1;
    async_req = 1'b1;
    @(negedge clk);
    async_req = 1'b0;
    rst       = 1'b0;
    lit_en    = 1'b1;
    lit_out   = 32'hB5B5_B5B5;
    lit_co    = 1'b0;

    // Random sweep: every opcode held for two cycles per operand set.
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      logic        rc;
      rx = $urandom;
      ry = $urandom;
      rc = 1'($urandom_range(0, 1));
      for (int op = 0; op < 8; op++) begin
        drive(3'(op), rx, ry, rc, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
      end
    end

    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish, required completion");
      $fatal(1, "timeout");
    end
  end

endmodule
